// File: rtl/serial_frame_deserializer.sv
// Start/stop framed serial-to-parallel converter fed by an enable-strobed bit stream.
// Assembled words are held in a valid/ready output register, with overrun and framing-error pulses.
module serial_frame_deserializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             D,
  input  logic             Enable,
  input  logic             Ready,
  output logic [WIDTH-1:0] Data,
  output logic             Valid,
  output logic             Busy,
  output logic             Overrun,
  output logic             FrameError
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, STOP} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             commit;
  logic             consume;

  // Bit order decides which end of the shift register a new bit enters.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign sr_next = {sr[WIDTH-2:0], D};
    end else begin : g_lsb_first
      assign sr_next = {D, sr[WIDTH-1:1]};
    end
  endgenerate

  assign commit  = Enable && (state == STOP) && D;
  assign consume = Valid && Ready;
  assign Busy    = (state != IDLE);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      sr         <= '0;
      Data       <= '0;
      Valid      <= 1'b0;
      Overrun    <= 1'b0;
      FrameError <= 1'b0;
    end else begin
      Overrun    <= 1'b0;
      FrameError <= 1'b0;

      if (Enable) begin
        case (state)
          IDLE: begin
            if (!D) begin
              state <= SHIFT;
              cnt   <= '0;
            end
          end
          SHIFT: begin
            sr  <= sr_next;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!D) FrameError <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end

      // A commit can replace a word being consumed in the same cycle; otherwise it is dropped.
      if (commit) begin
        if (!Valid || Ready) begin
          Data  <= sr;
          Valid <= 1'b1;
        end else begin
          Overrun <= 1'b1;
        end
      end else if (consume) begin
        Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Drives one LSB-first and one MSB-first deserializer from a shared bit stream and
// compares every cycle against a frame-level model, plus directed checks on key values.
module tb_serial_frame_deserializer;

  logic       Clock = 1'b0;
  logic       Reset, D, Enable, Ready;
  logic [7:0] data0, data1;
  logic       v0, v1, b0, b1, o0, o1, f0, f1;

  int errs   = 0;
  int checks = 0;
  bit rnd_ready = 0;

  always #5 Clock = ~Clock;

  serial_frame_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut0 (
    .Clock(Clock), .Reset(Reset), .D(D), .Enable(Enable), .Ready(Ready),
    .Data(data0), .Valid(v0), .Busy(b0), .Overrun(o0), .FrameError(f0));

  serial_frame_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .D(D), .Enable(Enable), .Ready(Ready),
    .Data(data1), .Valid(v1), .Busy(b1), .Overrun(o1), .FrameError(f1));

  // Frame-level model: phase 0 idle, 1 collecting data bits, 2 awaiting stop bit.
  int         ph  [2];
  int         nb  [2];
  bit         bits[2][8];
  logic [7:0] md  [2];
  bit         mv  [2], mo[2], mf[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit         commit;
      logic [7:0] w;
      commit = 0;
      w      = '0;
      if (Reset) begin
        ph[k] = 0; nb[k] = 0; md[k] = '0; mv[k] = 0; mo[k] = 0; mf[k] = 0;
      end else begin
        mo[k] = 0;
        mf[k] = 0;
        if (Enable) begin
          if (ph[k] == 0) begin
            if (!D) begin ph[k] = 1; nb[k] = 0; end
          end else if (ph[k] == 1) begin
            bits[k][nb[k]] = D;
            nb[k]++;
            if (nb[k] == 8) ph[k] = 2;
          end else begin
            ph[k] = 0;
            if (D) begin
              commit = 1;
              for (int i = 0; i < 8; i++)
                if (bits[k][i]) w = w | ((k == 1) ? (8'h80 >> i) : (8'h01 << i));
            end else begin
              mf[k] = 1;
            end
          end
        end
        if (commit) begin
          if (!mv[k] || Ready) begin md[k] = w; mv[k] = 1; end
          else mo[k] = 1;
        end else if (mv[k] && Ready) begin
          mv[k] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("d0.data",  {24'h0, data0}, {24'h0, md[0]});
    chk("d0.valid", {31'h0, v0},    {31'h0, mv[0]});
    chk("d0.busy",  {31'h0, b0},    {31'h0, ph[0] != 0});
    chk("d0.ovr",   {31'h0, o0},    {31'h0, mo[0]});
    chk("d0.ferr",  {31'h0, f0},    {31'h0, mf[0]});
    chk("d1.data",  {24'h0, data1}, {24'h0, md[1]});
    chk("d1.valid", {31'h0, v1},    {31'h0, mv[1]});
    chk("d1.busy",  {31'h0, b1},    {31'h0, ph[1] != 0});
    chk("d1.ovr",   {31'h0, o1},    {31'h0, mo[1]});
    chk("d1.ferr",  {31'h0, f1},    {31'h0, mf[1]});
  endtask

  task automatic tick();
    @(posedge Clock);
    model_step();
    #1;
    compare_all();
  endtask

  // gap cycles with Enable=0 and junk on D, then one strobed bit.
  task automatic send_bit(input logic b, input int gap);
    for (int i = 0; i < gap; i++) begin
      Enable = 1'b0;
      D      = 1'($urandom);
      if (rnd_ready) Ready = 1'($urandom);
      tick();
    end
    Enable = 1'b1;
    D      = b;
    if (rnd_ready) Ready = 1'($urandom);
    tick();
    Enable = 1'b0;
  endtask

  // tx[0] is transmitted first.
  task automatic send_frame(input logic [7:0] tx, input logic stop, input int gap,
                            input logic stop_ready);
    logic saved;
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(tx[i], gap);
    saved = Ready;
    if (!rnd_ready) Ready = stop_ready;
    send_bit(stop, gap);
    if (!rnd_ready) Ready = saved;
  endtask

  task automatic consume();
    Ready = 1'b1; Enable = 1'b0;
    tick();
    Ready = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; D = 1'b0; Enable = 1'b1; Ready = 1'b0;
    tick();
    tick();
    chk("rst_busy",  {31'h0, b0},    32'h0);
    chk("rst_valid", {31'h0, v0},    32'h0);
    chk("rst_data",  {24'h0, data0}, 32'h0);
    Reset = 1'b0; Enable = 1'b0;
    tick();

    // Basic frame, every cycle strobed
    send_frame(8'hA5, 1'b1, 0, 1'b0);
    chk("basic_valid", {31'h0, v0},    32'h1);
    chk("basic_data",  {24'h0, data0}, 32'hA5);
    chk("msb_a5",      {24'h0, data1}, 32'hA5);
    consume();
    chk("basic_consumed", {31'h0, v0}, 32'h0);

    // Reset on the 4th data bit discards the partial frame
    send_bit(1'b0, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    Reset = 1'b1; Enable = 1'b1; D = 1'b1;
    tick();
    chk("midrst_busy", {31'h0, b0}, 32'h0);
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) send_bit(1'b1, 0);
    chk("midrst_novalid", {31'h0, v0}, 32'h0);

    // Sparse strobes with junk between them
    send_frame(8'h5A, 1'b1, 4, 1'b0);
    chk("sparse_data", {24'h0, data0}, 32'h5A);
    consume();

    // MSB-first: bits 1,1,0,0,0,0,0,0
    send_frame(8'h03, 1'b1, 1, 1'b0);
    chk("msb_c0", {24'h0, data1}, 32'hC0);
    chk("lsb_03", {24'h0, data0}, 32'h03);
    consume();

    // Overrun, then replacement with Ready on the commit cycle
    send_frame(8'h3C, 1'b1, 0, 1'b0);
    send_frame(8'h81, 1'b1, 0, 1'b0);
    chk("ovr_pulse", {31'h0, o0},    32'h1);
    chk("ovr_data",  {24'h0, data0}, 32'h3C);
    tick();
    chk("ovr_single", {31'h0, o0}, 32'h0);
    send_frame(8'h81, 1'b1, 0, 1'b1);
    chk("repl_data",  {24'h0, data0}, 32'h81);
    chk("repl_valid", {31'h0, v0},    32'h1);
    chk("repl_noovr", {31'h0, o0},    32'h0);

    // Framing error leaves the held word alone
    send_frame(8'hFF, 1'b0, 0, 1'b0);
    chk("ferr_pulse", {31'h0, f0},    32'h1);
    chk("ferr_valid", {31'h0, v0},    32'h1);
    chk("ferr_data",  {24'h0, data0}, 32'h81);
    tick();
    chk("ferr_single", {31'h0, f0}, 32'h0);
    consume();
    send_frame(8'h12, 1'b1, 0, 1'b0);
    chk("after_ferr", {24'h0, data0}, 32'h12);

    // Randomized traffic
    rnd_ready = 1;
    for (int n = 0; n < 200; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) begin
        int nbits;
        nbits = $urandom_range(0, 9);
        send_bit(1'b0, gap);
        for (int i = 0; i < nbits; i++) send_bit(1'($urandom), gap);
        Reset = 1'b1; Enable = 1'($urandom); D = 1'($urandom);
        tick();
        Reset = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) send_bit(1'b1, gap);
        send_frame(8'($urandom), ($urandom_range(0, 7) != 0), gap, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
